mult_div_unit: RTL

//  E-stage multiply/divide unit; consumes the MDU control and operand fields launched by the D->E pipeline register.

---
 rtl/mult_div_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Execute-stage multiply/divide unit. Owns the HI/LO registers and runs
//   MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency. MTHI/MTLO write HI/LO
//   in one cycle; MFHI/MFLO read them combinationally through MD_OUT.
// Parameters
//   MULT_CYCLES : busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES  : busy cycles for DIV/DIVU (>=1)
// Ports
//   clk          in   rising-edge clock
//   RESET_N      in   asynchronous active-low reset
//   E_ISMULTDIV  in   E-stage instruction is an MDU instruction
//   E_MULTSel    in   [2:0] op: 0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO
//   E_V1, E_V2   in   [31:0] forwarded rs / rt values
//   START        out  arithmetic op accepted this cycle (combinational)
//   BUSY         out  arithmetic op in flight
//   HI, LO       out  [31:0] architectural HI/LO registers
//   MD_OUT       out  [31:0] MFHI/MFLO result, zero otherwise
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        E_ISMULTDIV,
    input  logic [2:0]  E_MULTSel,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    output logic        START,
    output logic        BUSY,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_OUT
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } op_e;

    op_e               op_q, op_d;
    logic [31:0]       v1_q, v1_d, v2_q, v2_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [63:0]       res;     // {HI, LO} produced by the latched operation
    logic              res_wr;  // result is written back when the op completes
    logic              start;
    op_e               sel;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [63:0] ae, be;
        ae = 64'(a);
        be = 64'(b);
        return ae * be;
    endfunction

    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Returns {remainder, quotient}. The single overflow case is pinned explicitly
    // so it never depends on how the tool wraps -2^31 / -1.
    function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
        logic signed [31:0] q, r;
        if (b == 32'sd0) begin
            q = '0;
            r = '0;
        end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
            q = a;
            r = '0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) begin
            return 64'd0;
        end
        return {a % b, a / b};
    endfunction

    assign sel   = op_e'(E_MULTSel);
    assign start = E_ISMULTDIV && (E_MULTSel <= 3'd3) && !busy_q;

    always_comb begin
        res    = '0;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT:  begin res = mul_signed(v1_q, v2_q);   res_wr = 1'b1;           end
            OP_MULTU: begin res = mul_unsigned(v1_q, v2_q); res_wr = 1'b1;           end
            // Divide by zero keeps the full latency but leaves HI/LO untouched.
            OP_DIV:   begin res = div_signed(v1_q, v2_q);   res_wr = (v2_q != '0);   end
            OP_DIVU:  begin res = div_unsigned(v1_q, v2_q); res_wr = (v2_q != '0);   end
            default:  begin res = '0;                       res_wr = 1'b0;           end
        endcase
    end

    always_comb begin
        op_d   = op_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            // Any MDU request while busy is dropped; operands stay latched.
            if (cnt_q == ONE) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (res_wr) begin
                    {hi_d, lo_d} = res;
                end
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end else if (start) begin
            op_d   = sel;
            v1_d   = E_V1;
            v2_d   = E_V2;
            busy_d = 1'b1;
            cnt_d  = E_MULTSel[1] ? DIV_N : MULT_N;
        end else if (E_ISMULTDIV) begin
            if (sel == OP_MTHI) hi_d = E_V1;
            if (sel == OP_MTLO) lo_d = E_V1;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            op_q   <= OP_MULT;
            v1_q   <= '0;
            v2_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign START  = start;
    assign BUSY   = busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MD_OUT = (E_ISMULTDIV && sel == OP_MFHI) ? hi_q :
                    (E_ISMULTDIV && sel == OP_MFLO) ? lo_q : 32'd0;

endmodule
